// File: rtl/mrv32_mem_arbiter.sv
// Two-requester round-robin arbiter for one memory port, with burst lock,
// lock-idle timeout and fixed-latency read response routing.
module mrv32_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int RD_LATENCY   = 2,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  input  logic                  m0_lock,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  input  logic                  m1_lock,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rvalid,
  output logic                  s_valid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [31:0]           s_rdata,
  input  logic                  s_rvalid,
  output logic                  err_spurious
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam int IDLE_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(RD_LATENCY + 1);

  state_t                state_r;
  logic                  last_grant_r;
  logic [IDLE_W-1:0]     idle_cnt_r;
  logic [RD_LATENCY-1:0] rd_v_r;
  logic [RD_LATENCY-1:0] rd_id_r;
  logic [DRAIN_W-1:0]    drain_cnt_r;
  logic                  err_spurious_r;

  logic gnt_valid_s;
  logic gnt_id_s;
  logic gnt_lock_s;
  logic timeout_s;
  logic rd_load_s;
  logic rd_v_last_s;
  logic rd_id_last_s;
  logic err_set_s;

  // Grant selection; everything is held off while reset is asserted
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (!rst_n) begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end else begin
      case (state_r)
        ST_ARB: begin
          if (m0_valid && m1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = ~last_grant_r;
          end else if (m0_valid) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = 1'b0;
          end else if (m1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = 1'b1;
          end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
          end
        end
        ST_LOCK0: begin
          gnt_valid_s = m0_valid;
          gnt_id_s    = 1'b0;
        end
        ST_LOCK1: begin
          gnt_valid_s = m1_valid;
          gnt_id_s    = 1'b1;
        end
        default: begin
          gnt_valid_s = 1'b0;
          gnt_id_s    = 1'b0;
        end
      endcase
    end
  end

  assign s_valid    = gnt_valid_s;
  assign s_addr     = gnt_id_s ? m1_addr  : m0_addr;
  assign s_wdata    = gnt_id_s ? m1_wdata : m0_wdata;
  assign s_wstrb    = gnt_id_s ? m1_wstrb : m0_wstrb;
  assign gnt_lock_s = gnt_id_s ? m1_lock  : m0_lock;
  assign m0_ready   = gnt_valid_s & ~gnt_id_s;
  assign m1_ready   = gnt_valid_s & gnt_id_s;

  // Release fires on the idle cycle that brings the count to LOCK_TIMEOUT-1
  assign timeout_s = (int'(idle_cnt_r) + 32'sd1) >= (LOCK_TIMEOUT - 32'sd1);

  // Arbitration state, round-robin pointer and lock idle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_ARB;
      last_grant_r <= 1'b1;
      idle_cnt_r   <= {IDLE_W{1'b0}};
    end else if (gnt_valid_s) begin
      last_grant_r <= gnt_id_s;
      idle_cnt_r   <= {IDLE_W{1'b0}};
      if (gnt_lock_s) begin
        state_r <= gnt_id_s ? ST_LOCK1 : ST_LOCK0;
      end else begin
        state_r <= ST_ARB;
      end
    end else if (state_r != ST_ARB) begin
      if (timeout_s) begin
        state_r    <= ST_ARB;
        idle_cnt_r <= {IDLE_W{1'b0}};
      end else begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end
    end else begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end
  end

  assign rd_load_s    = gnt_valid_s && (s_wstrb == 4'h0);
  assign rd_v_last_s  = rd_v_r[RD_LATENCY-1];
  assign rd_id_last_s = rd_id_r[RD_LATENCY-1];

  assign m0_rvalid = rst_n & s_rvalid & rd_v_last_s & ~rd_id_last_s;
  assign m1_rvalid = rst_n & s_rvalid & rd_v_last_s & rd_id_last_s;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  // Untracked responses are tolerated only while the post-reset drain runs
  assign err_set_s = (s_rvalid & ~rd_v_last_s & (drain_cnt_r == {DRAIN_W{1'b0}}))
                   | (rd_v_last_s & ~s_rvalid);

  // Read tracking pipeline, post-reset drain and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v_r         <= {RD_LATENCY{1'b0}};
      rd_id_r        <= {RD_LATENCY{1'b0}};
      drain_cnt_r    <= DRAIN_W'(RD_LATENCY);
      err_spurious_r <= 1'b0;
    end else begin
      rd_v_r[0]  <= rd_load_s;
      rd_id_r[0] <= gnt_id_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_v_r[i]  <= rd_v_r[i-1];
        rd_id_r[i] <= rd_id_r[i-1];
      end
      if (drain_cnt_r != {DRAIN_W{1'b0}}) begin
        drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
      end else begin
        drain_cnt_r <= drain_cnt_r;
      end
      if (err_set_s) begin
        err_spurious_r <= 1'b1;
      end else begin
        err_spurious_r <= err_spurious_r;
      end
    end
  end

  assign err_spurious = err_spurious_r;

endmodule

// File: tb/tb_mrv32_mem_arbiter.sv
// Bench for mrv32_mem_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model and a memory model.
module tb_mrv32_mem_arbiter;

  localparam int AW = 16;
  localparam int L  = 2;
  localparam int LT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_valid, m1_valid, m0_lock, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic [31:0]   s_rdata;
  logic          s_rvalid;
  logic          err_spurious;

  always #5 clk = ~clk;

  mrv32_mem_arbiter #(.ADDR_WIDTH(AW), .RD_LATENCY(L), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_lock(m0_lock), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_lock(m1_lock), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .err_spurious(err_spurious)
  );

  // Memory behind the port: fixed-latency pipe driven by the DUT's s_* side
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [L-1:0] pv;
  logic [31:0]  pd [L];
  logic inj_rv, inj_drop;
  assign s_rvalid = (pv[L-1] & ~inj_drop) | inj_rv;
  assign s_rdata  = pd[L-1];

  typedef struct { int due; int id; logic [31:0] data; } rsp_t;
  rsp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int lk_owner, m_last, m_idle, m_drain;
  bit m_err;
  logic obs_m0_ready, obs_m1_ready, obs_m0_rvalid, obs_m1_rvalid, obs_s_valid, obs_err;
  logic [31:0] obs_m0_rdata, obs_m1_rdata;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic model_reset();
    lk_owner = -1; m_last = 1; m_idle = 0; m_drain = L; m_err = 1'b0;
    q.delete();
  endtask

  // One clock: check outputs against the model, advance model and memory
  task automatic step();
    int g;
    bit tracked;
    logic [AW-1:0] ra;
    logic [31:0] rd;
    logic [3:0] rs;
    logic cv;
    logic [AW-1:0] ca;
    logic [31:0] cd;
    logic [3:0] cs;
    @(negedge clk);
    g = -1;
    if (rst_n) begin
      if (lk_owner >= 0) begin
        if (lk_owner == 0 ? m0_valid : m1_valid) g = lk_owner;
      end else if (m0_valid && m1_valid) g = 1 - m_last;
      else if (m0_valid) g = 0;
      else if (m1_valid) g = 1;
    end
    ra = (g == 1) ? m1_addr : m0_addr;
    rd = (g == 1) ? m1_wdata : m0_wdata;
    rs = (g == 1) ? m1_wstrb : m0_wstrb;
    tracked = rst_n && q.size() > 0 && q[0].due == cyc;
    obs_m0_ready = m0_ready; obs_m1_ready = m1_ready; obs_s_valid = s_valid;
    obs_m0_rvalid = m0_rvalid; obs_m1_rvalid = m1_rvalid; obs_err = err_spurious;
    obs_m0_rdata = m0_rdata; obs_m1_rdata = m1_rdata;
    chk("m0_ready", 32'(m0_ready), 32'(g == 0));
    chk("m1_ready", 32'(m1_ready), 32'(g == 1));
    chk("s_valid", 32'(s_valid), 32'(g >= 0));
    if (g >= 0) begin
      chk("s_addr", 32'(s_addr), 32'(ra));
      chk("s_wstrb", 32'(s_wstrb), 32'(rs));
      if (rs != 4'h0) chk("s_wdata", s_wdata, rd);
    end
    chk("m0_rvalid", 32'(m0_rvalid), 32'(tracked && s_rvalid && q[0].id == 0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(tracked && s_rvalid && q[0].id == 1));
    if (tracked && s_rvalid) chk(q[0].id == 0 ? "m0_rdata" : "m1_rdata",
                                 q[0].id == 0 ? m0_rdata : m1_rdata, q[0].data);
    chk("err_spurious", 32'(err_spurious), 32'(m_err));
    if (!rst_n) begin
      model_reset();
    end else begin
      if ((s_rvalid && !tracked && m_drain == 0) || (tracked && !s_rvalid)) m_err = 1'b1;
      if (tracked) void'(q.pop_front());
      if (m_drain > 0) m_drain--;
      if (g >= 0) begin
        if (rs == 4'h0) q.push_back('{cyc + L, g, ref_mem[ra[AW-1:2]]});
        else for (int b = 0; b < 4; b++)
          if (rs[b]) ref_mem[ra[AW-1:2]][8*b +: 8] = rd[8*b +: 8];
        m_last = g;
        lk_owner = ((g == 1) ? m1_lock : m0_lock) ? g : -1;
        m_idle = 0;
      end else if (lk_owner >= 0) begin
        m_idle++;
        if (m_idle >= LT - 1) begin lk_owner = -1; m_idle = 0; end
      end
    end
    cv = s_valid; ca = s_addr; cd = s_wdata; cs = s_wstrb;
    @(posedge clk);
    #1;
    for (int i = L - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
    pv[0] = cv && (cs == 4'h0);
    pd[0] = mem[ca[AW-1:2]];
    if (cv && cs != 4'h0) for (int b = 0; b < 4; b++)
      if (cs[b]) mem[ca[AW-1:2]][8*b +: 8] = cd[8*b +: 8];
    cyc++;
  endtask

  task automatic set_m0(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic lk);
    m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_lock = lk;
  endtask

  task automatic set_m1(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic lk);
    m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_lock = lk;
  endtask

  task automatic rand_req(input int n);
    logic v, lk;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0] s;
    v  = ($urandom_range(0, 3) != 0);
    a  = AW'($urandom_range(0, 15) * 4);
    d  = $urandom;
    s  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    lk = ($urandom_range(0, 3) == 0);
    if (n == 0) set_m0(v, a, d, s, lk);
    else        set_m1(v, a, d, s, lk);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16384; i++) begin mem[i] = init_word(i); ref_mem[i] = init_word(i); end
    pv = '0; for (int i = 0; i < L; i++) pd[i] = 32'h0;
    inj_rv = 1'b0; inj_drop = 1'b0;
    set_m0(1'b1, 16'h0000, 32'h0, 4'h0, 1'b0);
    set_m1(1'b1, 16'h0004, 32'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    chk("reset_s_valid", 32'(obs_s_valid), 32'h0);
    rst_n = 1'b1;

    // Contended reads from release onward
    set_m0(1'b1, 16'h0100, 32'h0, 4'h0, 1'b0);
    set_m1(1'b1, 16'h0200, 32'h0, 4'h0, 1'b0);
    step(); chk("cont_g0_m0", 32'(obs_m0_ready), 32'h1);
    step(); chk("cont_g1_m1", 32'(obs_m1_ready), 32'h1);
    step(); chk("cont_g2_m0", 32'(obs_m0_ready), 32'h1);
    chk("cont_rv0", 32'(obs_m0_rvalid), 32'h1);
    chk("cont_rd0", obs_m0_rdata, init_word(16'h0100 >> 2));
    set_m0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0); set_m1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    step(); chk("cont_rv1", 32'(obs_m1_rvalid), 32'h1);
    chk("cont_rd1", obs_m1_rdata, init_word(16'h0200 >> 2));
    repeat (2) step();

    // Single write, then read back
    set_m1(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0);
    step(); chk("wr_ready", 32'(obs_m1_ready), 32'h1);
    set_m1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("wr_no_rvalid", 32'(obs_m0_rvalid | obs_m1_rvalid), 32'h0);
    end
    set_m0(1'b1, 16'h0010, 32'h0, 4'h0, 1'b0);
    step();
    set_m0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    step(); step();
    chk("rdback_rv", 32'(obs_m0_rvalid), 32'h1);
    chk("rdback_data", obs_m0_rdata, 32'hDEADBEEF);

    // Burst lock by m1 while m0 waits
    set_m0(1'b1, 16'h0020, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_m1(1'b1, AW'(16'h0030 + i * 4), 32'h11110000 + 32'(i), 4'hF, (i < 3) ? 1'b1 : 1'b0);
      step();
      chk("burst_m1_ready", 32'(obs_m1_ready), 32'h1);
      chk("burst_m0_blocked", 32'(obs_m0_ready), 32'h0);
    end
    set_m1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    step(); chk("burst_m0_after", 32'(obs_m0_ready), 32'h1);
    set_m0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    repeat (3) step();

    // Lock timeout: m1 locks then goes idle
    set_m1(1'b1, 16'h0040, 32'hCAFEF00D, 4'hF, 1'b1);
    step(); chk("to_m1_lock", 32'(obs_m1_ready), 32'h1);
    set_m1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    set_m0(1'b1, 16'h0044, 32'h0, 4'h0, 1'b0);
    for (k = 1; k <= 20; k++) begin
      step();
      if (obs_m0_ready) break;
    end
    chk("lock_timeout", 32'(k), 32'd8);
    set_m0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    repeat (3) step();

    // Missing response for a tracked read, then reset clears the flag
    set_m0(1'b1, 16'h0008, 32'h0, 4'h0, 1'b0);
    step();
    set_m0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    step();
    inj_drop = 1'b1;
    step(); chk("drop_no_rvalid", 32'(obs_m0_rvalid), 32'h0);
    inj_drop = 1'b0;
    step(); chk("drop_err", 32'(obs_err), 32'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    step(); chk("drop_err_cleared", 32'(obs_err), 32'h0);
    repeat (3) step();

    // Spurious response with nothing outstanding
    inj_rv = 1'b1;
    step(); chk("spur_no_rvalid", 32'(obs_m0_rvalid | obs_m1_rvalid), 32'h0);
    inj_rv = 1'b0;
    step(); chk("spur_err", 32'(obs_err), 32'h1);
    repeat (3) step();

    // Reset the cycle after a read is accepted
    set_m0(1'b1, 16'h0100, 32'h0, 4'h0, 1'b0);
    step();
    set_m0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    step();
    chk("rstrd_no_rvalid", 32'(obs_m0_rvalid | obs_m1_rvalid), 32'h0);
    chk("rstrd_err", 32'(obs_err), 32'h0);
    set_m0(1'b1, 16'h0004, 32'h0, 4'h0, 1'b0);
    set_m1(1'b1, 16'h0008, 32'h0, 4'h0, 1'b0);
    step(); chk("rstrd_tie_m0", 32'(obs_m0_ready), 32'h1);
    chk("rstrd_err_late", 32'(obs_err), 32'h0);

    // Random traffic; requests are held until accepted
    rand_req(0); rand_req(1);
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!m0_valid || obs_m0_ready) rand_req(0);
      if (!m1_valid || obs_m1_ready) rand_req(1);
    end
    set_m0(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    set_m1(1'b0, 16'h0, 32'h0, 4'h0, 1'b0);
    repeat (L + 2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mrv32_mem_arbiter.md
# mrv32_mem_arbiter

Two-requester arbiter that shares one port of `dual_port_byte_mem` (normally the data port B) between the core LSU (requester 0) and a DMA/debug loader (requester 1). It uses round-robin grant with an optional burst lock and a lock-idle timeout. Read responses are routed back to the issuing requester by tracking each accepted read through a fixed `RD_LATENCY` pipeline. It sits between `mrv32_core`/loader and the memory, replacing the direct core-to-port-B wiring.

## Interface
- `ADDR_WIDTH`, default 16: byte address width, must match the memory.
- `RD_LATENCY`, default 2: memory read latency in cycles, ≥1.
- `LOCK_TIMEOUT`, default 8: idle cycles before a held lock is forcibly released, ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mN_valid` in 1 (N=0,1): request valid. Held with addr, wdata, wstrb and lock until `mN_ready`.
- `mN_addr` in ADDR_WIDTH: byte address.
- `mN_wdata` in 32: write data.
- `mN_wstrb` in 4: byte strobes. 0 means read.
- `mN_lock` in 1: keep the grant after this beat.
- `mN_ready` out 1: request accepted this cycle.
- `mN_rdata` out 32: read data, equal to `s_rdata`.
- `mN_rvalid` out 1: read response for requester N.
- `s_valid`, `s_addr`, `s_wdata`, `s_wstrb` out 1/ADDR_WIDTH/32/4: memory request.
- `s_rdata` in 32, `s_rvalid` in 1: memory response.
- `err_spurious` out 1: sticky flag; `s_rvalid` arrived with no tracked read.

## Operation
- **FSM states:** ARB, LOCK0, LOCK1. A register `last_grant` records the last requester granted; its reset value is 1.
- **ARB state:**
  - Only one valid requester: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - Neither valid: no grant.
- **LOCKn state:** only requester n can be granted; the other requester's ready stays 0.
- **Grant is combinational:**
  - `s_valid` = granted `valid`; `s_addr`/`s_wdata`/`s_wstrb` are muxed from the granted requester.
  - `mN_ready` = `s_valid` && (grant == N).
  - The memory accepts every cycle, so accept = `s_valid`.
- **On accept by requester n:**
  - `last_grant` ← n.
  - If `mn_lock`=1, next state is LOCKn.
  - If `mn_lock`=0, next state is ARB (this also exits LOCKn).
- **Lock timeout:**
  - In LOCKn, `idle_cnt` increments each cycle that `mn_valid`=0. It clears on any accept and on entry to LOCKn.
  - When `idle_cnt` reaches LOCK_TIMEOUT-1 while still idle, the next state is ARB.
- **Response tracking:**
  - Shift registers `rd_v[RD_LATENCY]` and `rd_id[RD_LATENCY]`. Stage 0 loads (accept && `s_wstrb`==0, grant id); every stage shifts each cycle.
  - At the last stage: `mN_rvalid` = `s_rvalid` && `rd_v` && (`rd_id`==N).
  - `s_rvalid` with the last-stage `rd_v`=0 sets `err_spurious`, and the response is dropped.
  - `rd_v`=1 with `s_rvalid`=0 is also treated as an error and sets `err_spurious`.
- **Writes:** complete on accept; no response is generated or tracked.
- **Reset:**
  - State returns to ARB, `last_grant`=1, `idle_cnt`=0, all `rd_v`=0, `err_spurious`=0.
  - While `rst_n`=0, `s_valid`, `mN_ready` and `mN_rvalid` are forced to 0.
  - Reads in flight across reset are discarded without setting `err_spurious`. For RD_LATENCY cycles after reset release, `s_rvalid` with no tracked read is ignored (a drain counter).

## Timing
- Request path is combinational (`mN_valid` → `s_valid`/`mN_ready`); no added latency.
- Read response is observed by the requester exactly RD_LATENCY cycles after accept, in the same cycle as `s_rvalid`.
- Back-to-back accepts of any mix of requesters are allowed every cycle; responses stay in order.
- Alternation under contention: with both requesters continuously valid and unlocked, grants alternate 0,1,0,1…
- Simultaneous lock exit and new request: the beat with lock=0 is accepted in LOCKn, and the other requester can be granted on the next cycle.
- Output reset values: `s_valid`=0, `mN_ready`=0, `mN_rvalid`=0, `err_spurious`=0. `s_addr`/`s_wdata`/`s_wstrb`/`mN_rdata` are don't-care while not valid.

## Test plan
- **Contended reads:** RD_LATENCY=2, m0 reads 0x0100 and m1 reads 0x0200, both continuously valid from cycle 0. Required: grants m0@0, m1@1, m0@2. `m0_rvalid`@2 carries mem[0x0100], `m1_rvalid`@3 carries mem[0x0200].
- **Single write:** m1 writes 0xDEADBEEF to 0x0010 with wstrb=0xF. Required: `m1_ready`=1 in the same cycle, no rvalid ever. A later m0 read of 0x0010 returns 0xDEADBEEF.
- **Burst lock:** m1 does a 4-beat write burst (lock=1,1,1,0) while m0 is continuously valid. Required: m0 gets no ready for those 4 cycles, and is granted in the cycle after the last beat.
- **Lock timeout:** LOCK_TIMEOUT=8. m1 locks, then drops valid. Required: m0 is granted exactly 8 cycles after m1's last accept, and the state is ARB.
- **Spurious response:** force `s_rvalid`=1 with no read outstanding. Required: `err_spurious`=1 from the next cycle until reset, and no `mN_rvalid`.
- **Reset mid-read:** assert `rst_n`=0 in the cycle after a read is accepted, then release. Required: no `mN_rvalid`, `err_spurious`=0, and the first post-reset tie goes to m0.
